mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single memory request port (valid_i/wr_rd_i/addr_i/
//  wdata_i -> ready_o/rdata_o) between NREQ requesters. It latches one requester's command,
//  drives it to memory until ready_o is seen, then returns the response to that requester.
//  It sits between the masters (testbench agents or CPU-side logic) and the memory model.
// PARAMETERS
//  NREQ     2    number of requesters, 1..8
//  DATA_W   32   data width, equals `WIDTH
//  ADDR_W   8    address width, equals `ADDR_WIDTH
//  TMO_CYC  64   watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk_i          in   1              clock; all logic on the rising edge
//  rst_i          in   1              asynchronous reset, active-low
//  req_valid_i    in   NREQ           per-requester request valid
//  req_wr_rd_i    in   NREQ           per-requester 1=write, 0=read
//  req_addr_i     in   NREQ*ADDR_W    flattened addresses; requester k at [k*ADDR_W +: ADDR_W]
//  req_wdata_i    in   NREQ*DATA_W    flattened write data; same packing
//  req_ready_o    out  NREQ           one-hot completion pulse to the granted requester
//  req_rdata_o    out  DATA_W         read data, valid when any req_ready_o bit is high
//  gnt_o          out  NREQ           one-hot current grant, 0 when IDLE
//  valid_o        out  1              to memory valid_i
//  wr_rd_o        out  1              to memory wr_rd_i
//  addr_o         out  ADDR_W         to memory addr_i
//  wdata_o        out  DATA_W         to memory wdata_i
//  ready_i        in   1              from memory ready_o
//  rdata_i        in   DATA_W         from memory rdata_o, valid in the cycle ready_i=1
//  err_o          out  1              timeout pulse (tied 0 without MEM_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE; valid_o, wr_rd_o, addr_o, wdata_o, gnt_o, err_o = 0;
//   rr pointer=NREQ-1, so requester 0 has top priority first. An in-flight transfer is dropped
//   and valid_o falls immediately.
//  FSM IDLE -> BUSY: in IDLE, if any req_valid_i bit is set, pick the first set bit searching
//   from (ptr+1) mod NREQ upward with wrap. At that edge, register gnt_o, wr_rd_o, addr_o and
//   wdata_o, set valid_o=1 and ptr=winner. Latency: request sampled at edge N, valid_o high after N.
//  BUSY: hold all memory outputs stable. req_ready_o = gnt_o & {NREQ{ready_i}} (combinational).
//   req_rdata_o = rdata_i (combinational pass-through).
//  BUSY -> IDLE: on an edge with ready_i=1, clear valid_o and gnt_o. There is always >=1 IDLE cycle
//   between transfers, so the minimum transfer period is 2 cycles when ready_i is already high.
//  Requester rule: hold req_valid_i and its command until its req_ready_o pulse. Dropping or
//   changing them while granted has no effect, because the latched command still completes.
//  Simultaneous requests: strict rotation, so no requester waits more than NREQ-1 grants.
//   A single requester re-requesting is granted every second cycle.
//  ready_i high in IDLE is ignored. With NREQ=1 the block is a registered pass-through.
//  Write data is never checked. For writes, req_rdata_o is don't-care.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: an 8-bit watchdog counter clears when the block enters BUSY and
//   increments every BUSY cycle with ready_i=0. When it reaches TMO_CYC-1, the next edge forces
//   IDLE, clears valid_o, pulses err_o for 1 cycle and pulses req_ready_o of the granted requester
//   with req_rdata_o forced to 0. ptr still advances.
//  Not defined: no counter; BUSY waits indefinitely for ready_i; err_o=0.
// TESTING
//  1 Reset: hold rst_i=0 while req_valid_i=2'b11 -> valid_o=0, gnt_o=0, req_ready_o=0.
//  2 Single write: req0 wr addr=8'h10 wdata=32'hA5A5_0001, memory ready_i 1 cycle later ->
//    valid_o high for 2 cycles, addr_o=8'h10, req_ready_o=2'b01 for 1 cycle.
//  3 Read: req1 rd addr=8'h3C, ready_i=1 with rdata_i=32'hDEAD_BEEF -> req_ready_o=2'b10 in
//    the same cycle, req_rdata_o=32'hDEAD_BEEF.
//  4 Contention: both requesters held high for 6 transfers -> grant order 0,1,0,1,0,1.
//    Each req_ready_o is one-hot.
//  5 Reset mid-transfer: rst_i=0 while BUSY -> valid_o falls asynchronously. After release,
//    a pending req0 is granted first.
//  6 MEM_ARB_TIMEOUT_EN, TMO_CYC=64, ready_i stuck 0 -> err_o pulses 64 cycles after valid_o
//    rises; req_ready_o pulses with rdata 0; the next requester is granted.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory request port between NREQ requesters.
// Optional watchdog on stalled transfers is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ-1:0]        req_wr_rd_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]      req_rdata_o,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   valid_o,
  output logic                   wr_rd_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [DATA_W-1:0]      wdata_o,
  input  logic                   ready_i,
  input  logic [DATA_W-1:0]      rdata_i,
  output logic                   err_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("mem_rr_arbiter: NREQ must be 1..8");
  end
  if (TMO_CYC < 2 || TMO_CYC > 256) begin : g_bad_tmo
    $error("mem_rr_arbiter: TMO_CYC must fit the 8-bit watchdog");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;

  logic             win_found;
  int               win_idx;
  int               off;
  logic [NREQ-1:0]  win_onehot;
  logic             win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic             tmo_hit;

  // Search starts just past the last winner, so the previous winner ranks last.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = 0;
    off        = 0;
    win_onehot = '0;
    win_wr     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      off = (int'(ptr) + 1 + i) % NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!win_found && (k == off) && req_valid_i[k]) begin
          win_found = 1'b1;
          win_idx   = k;
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (k == win_idx) begin
        win_onehot[k] = win_found;
        win_wr        = req_wr_rd_i[k];
        win_addr      = req_addr_i[k*ADDR_W +: ADDR_W];
        win_wdata     = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wdog_cnt;

  assign tmo_hit = (state == BUSY) && !ready_i && (wdog_cnt == 8'(TMO_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= tmo_hit;
      if (state == IDLE) begin
        wdog_cnt <= '0;
      end else if (!ready_i && !tmo_hit) begin
        wdog_cnt <= wdog_cnt + 8'd1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  // A timed-out transfer completes toward its requester with zeroed read data.
  always_comb begin
    req_ready_o = gnt_o & {NREQ{ready_i | tmo_hit}};
    req_rdata_o = tmo_hit ? '0 : rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      ptr     <= PTR_W'(NREQ - 1);
      gnt_o   <= '0;
      valid_o <= 1'b0;
      wr_rd_o <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= BUSY;
            ptr     <= PTR_W'(win_idx);
            gnt_o   <= win_onehot;
            valid_o <= 1'b1;
            wr_rd_o <= win_wr;
            addr_o  <= win_addr;
            wdata_o <= win_wdata;
          end
        end
        BUSY: begin
          if (ready_i || tmo_hit) begin
            state   <= IDLE;
            gnt_o   <= '0;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_o   <= '0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with two requesters and a hand-driven memory side.
module tb_mem_rr_arbiter;

  localparam int NREQ   = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_wr_rd_i;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*DATA_W-1:0] req_wdata_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]      req_rdata_o;
  logic [NREQ-1:0]        gnt_o;
  logic                   valid_o;
  logic                   wr_rd_o;
  logic [ADDR_W-1:0]      addr_o;
  logic [DATA_W-1:0]      wdata_o;
  logic                   ready_i;
  logic [DATA_W-1:0]      rdata_i;
  logic                   err_o;

  int vectors     = 0;
  int miscompares = 0;

  mem_rr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMO_CYC(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_wr_rd_i(req_wr_rd_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o), .gnt_o(gnt_o),
    .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_valid_i = 2'b11; req_wr_rd_i = 2'b00; ready_i = 1'b1;
    req_addr_i = '0; req_wdata_i = '0; rdata_i = '0;
    tick(); tick(); tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_o); end
    vectors++; if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b want 00", req_ready_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
    req_valid_i = 2'b00; ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset_valid got %b want 0", valid_o); end
  endtask

  task automatic test_single_write();
    req_valid_i = 2'b01; req_wr_rd_i = 2'b01;
    req_addr_i[7:0] = 8'h10; req_wdata_i[31:0] = 32'hA5A5_0001;
    tick();
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL wr_valid got %b want 1", valid_o); end
    vectors++; if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL wr_gnt got %b want 01", gnt_o); end
    vectors++; if (addr_o !== 8'h10) begin miscompares++; $display("FAIL wr_addr got %h want 10", addr_o); end
    vectors++; if (wr_rd_o !== 1'b1) begin miscompares++; $display("FAIL wr_wr_rd got %b want 1", wr_rd_o); end
    vectors++; if (wdata_o !== 32'hA5A5_0001) begin miscompares++; $display("FAIL wr_wdata got %h want a5a50001", wdata_o); end
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL wr_early_ready got %b want 00", req_ready_o); end
    ready_i = 1'b1;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL wr_ready got %b want 01", req_ready_o); end
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL wr_valid_2nd got %b want 1", valid_o); end
    tick();
    req_valid_i = 2'b00; ready_i = 1'b0;
    #1;
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL wr_valid_fall got %b want 0", valid_o); end
    vectors++; if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL wr_gnt_clear got %b want 00", gnt_o); end
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL wr_ready_single got %b want 00", req_ready_o); end
  endtask

  task automatic test_read();
    req_valid_i = 2'b10; req_wr_rd_i = 2'b00; req_addr_i[15:8] = 8'h3C;
    tick();
    vectors++; if (gnt_o !== 2'b10) begin miscompares++; $display("FAIL rd_gnt got %b want 10", gnt_o); end
    vectors++; if (addr_o !== 8'h3C) begin miscompares++; $display("FAIL rd_addr got %h want 3c", addr_o); end
    vectors++; if (wr_rd_o !== 1'b0) begin miscompares++; $display("FAIL rd_wr_rd got %b want 0", wr_rd_o); end
    ready_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    #1;
    vectors++; if (req_ready_o !== 2'b10) begin miscompares++; $display("FAIL rd_ready got %b want 10", req_ready_o); end
    vectors++; if (req_rdata_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_rdata got %h want deadbeef", req_rdata_o); end
    tick();
    req_valid_i = 2'b00; ready_i = 1'b0; rdata_i = '0;
    #1;
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rd_valid_fall got %b want 0", valid_o); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_gnt;
    logic [ADDR_W-1:0] exp_addr;
    req_addr_i = {8'h21, 8'h20}; req_wr_rd_i = 2'b00;
    req_valid_i = 2'b11; ready_i = 1'b1;
    exp_gnt = 2'b01;
    for (int t = 0; t < 6; t++) begin
      exp_addr = (exp_gnt == 2'b01) ? 8'h20 : 8'h21;
      tick();
      vectors++; if (gnt_o !== exp_gnt) begin miscompares++; $display("FAIL cont_gnt[%0d] got %b want %b", t, gnt_o, exp_gnt); end
      vectors++; if (req_ready_o !== exp_gnt) begin miscompares++; $display("FAIL cont_ready[%0d] got %b want %b", t, req_ready_o, exp_gnt); end
      vectors++; if (addr_o !== exp_addr) begin miscompares++; $display("FAIL cont_addr[%0d] got %h want %h", t, addr_o, exp_addr); end
      tick();
      if (t == 5) req_valid_i = 2'b00;
      vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL cont_idle[%0d] valid got %b want 0", t, valid_o); end
      vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL cont_idle_ready[%0d] got %b want 00", t, req_ready_o); end
      exp_gnt = {exp_gnt[0], exp_gnt[1]};
    end
    ready_i = 1'b0;
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL cont_end_valid got %b want 0", valid_o); end
  endtask

  task automatic test_reset_mid_transfer();
    req_valid_i = 2'b01; req_wr_rd_i = 2'b01;
    tick();
    vectors++; if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL mid_pre_gnt got %b want 01", gnt_o); end
    #2;
    rst_i = 1'b0;
    #1;
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid got %b want 0", valid_o); end
    vectors++; if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL mid_async_gnt got %b want 00", gnt_o); end
    req_valid_i = 2'b11;
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_hold_valid got %b want 0", valid_o); end
    rst_i = 1'b1;
    tick();
    vectors++; if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL mid_regrant got %b want 01", gnt_o); end
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL mid_regrant_valid got %b want 1", valid_o); end
    req_valid_i = 2'b00; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid_i = 2'b01; req_wr_rd_i = 2'b00; ready_i = 1'b0; rdata_i = 32'h1234_5678;
    tick();
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL tmo_start got %b want 1", valid_o); end
    for (int c = 0; c < 63; c++) begin
      tick();
      if (err_o !== 1'b0 || valid_o !== 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL tmo_early[%0d] err %b valid %b want 0/1", c, err_o, valid_o);
      end
    end
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL tmo_ready got %b want 01", req_ready_o); end
    vectors++; if (req_rdata_o !== 32'h0) begin miscompares++; $display("FAIL tmo_rdata got %h want 0", req_rdata_o); end
    req_valid_i = 2'b10;
    tick();
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err got %b want 1", err_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL tmo_valid got %b want 0", valid_o); end
    tick();
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_err_pulse got %b want 0", err_o); end
    vectors++; if (gnt_o !== 2'b10) begin miscompares++; $display("FAIL tmo_next_gnt got %b want 10", gnt_o); end
    req_valid_i = 2'b00; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_reset_mid_transfer();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
